// File: rtl/cnn_accel_pkg.sv
// rtl/cnn_accel_pkg.sv - shared FSM encoding and default tile geometry for the CNN accelerator
package cnn_accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int DEF_N  = 32;
  localparam int DEF_R  = 64;
  localparam int DEF_C  = 32;
  localparam int DEF_TN = 8;
  localparam int DEF_TR = 16;
  localparam int DEF_TC = 8;

  // Counter width for a 0..depth-1 index; never narrower than one bit.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tile_idx_counter3.sv
// rtl/tile_idx_counter3.sv - three nested wrap-and-carry tile index counters
module tile_idx_counter3
  import cnn_accel_pkg::*;
#(
  parameter int D0 = DEF_TC,
  parameter int D1 = DEF_TR,
  parameter int D2 = DEF_TN,
  parameter int W0 = cnt_width(D0),
  parameter int W1 = cnt_width(D1),
  parameter int W2 = cnt_width(D2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [W0-1:0] cnt0,
  output logic [W1-1:0] cnt1,
  output logic [W2-1:0] cnt2,
  output logic          last
);

  localparam logic [W0-1:0] LP_MAX0 = W0'(D0 - 1);
  localparam logic [W1-1:0] LP_MAX1 = W1'(D1 - 1);
  localparam logic [W2-1:0] LP_MAX2 = W2'(D2 - 1);

  logic [W0-1:0] r_cnt0;
  logic [W1-1:0] r_cnt1;
  logic [W2-1:0] r_cnt2;
  logic          w_wrap0;
  logic          w_wrap1;
  logic          w_wrap2;

  assign w_wrap0 = (r_cnt0 == LP_MAX0);
  assign w_wrap1 = (r_cnt1 == LP_MAX1);
  assign w_wrap2 = (r_cnt2 == LP_MAX2);

  // Innermost counter steps on every enable; each wrap carries one level outward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
      r_cnt2 <= '0;
    end else if (clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
      r_cnt2 <= '0;
    end else if (en) begin
      if (w_wrap0) begin
        r_cnt0 <= '0;
        if (w_wrap1) begin
          r_cnt1 <= '0;
          r_cnt2 <= w_wrap2 ? '0 : r_cnt2 + W2'(1);
        end else begin
          r_cnt1 <= r_cnt1 + W1'(1);
        end
      end else begin
        r_cnt0 <= r_cnt0 + W0'(1);
      end
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
  assign cnt2 = r_cnt2;
  assign last = w_wrap0 && w_wrap1 && w_wrap2;

endmodule

// File: rtl/fifo_to_out_fm_ram.sv
// rtl/fifo_to_out_fm_ram.sv - drains one output tile from the result FIFO into the output feature-map RAM
module fifo_to_out_fm_ram
  import cnn_accel_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int N  = DEF_N,
  parameter int R  = DEF_R,
  parameter int C  = DEF_C,
  parameter int Tn = DEF_TN,
  parameter int Tr = DEF_TR,
  parameter int Tc = DEF_TC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          done,
  output logic          fifo_pop,
  input  logic          fifo_empty,
  input  logic [DW-1:0] data_from_fifo,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] data_to_ram,
  input  logic [AW-1:0] tile_base_n,
  input  logic [AW-1:0] tile_base_row,
  input  logic [AW-1:0] tile_base_col
);

  localparam int WN = cnt_width(Tn);
  localparam int WR = cnt_width(Tr);
  localparam int WC = cnt_width(Tc);

  localparam logic [AW-1:0] LP_RC    = AW'(R * C);
  localparam logic [AW-1:0] LP_C     = AW'(C);
  localparam logic [AW:0]   LP_LIM_N = (AW+1)'(N);
  localparam logic [AW:0]   LP_LIM_R = (AW+1)'(R);
  localparam logic [AW:0]   LP_LIM_C = (AW+1)'(C);

  state_t        r_state;
  state_t        w_next;
  logic          w_capture;
  logic          w_pop;
  logic          w_done;

  logic [AW-1:0] r_base_n;
  logic [AW-1:0] r_base_row;
  logic [AW-1:0] r_base_col;

  logic [WN-1:0] w_cnt_n;
  logic [WR-1:0] w_cnt_r;
  logic [WC-1:0] w_cnt_c;
  logic          w_last;

  logic [AW:0]   w_n_sum;
  logic [AW:0]   w_r_sum;
  logic [AW:0]   w_c_sum;
  logic          w_legal;
  logic [AW-1:0] w_addr;

  logic          r_s1_valid;
  logic          r_s1_legal;
  logic [AW-1:0] r_s1_addr;

  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  // State register; reset drops any tile in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state plus pop/capture/done strobes.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_pop     = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_capture = 1'b1;
          w_next    = ST_RUN;
        end
      end
      ST_RUN: begin
        w_pop = !fifo_empty;
        if (w_pop && w_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_s1_valid) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign fifo_pop = w_pop;
  assign done     = w_done;

  // Tile origin is frozen at the accepted start so the caller may change it mid-tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base_n   <= '0;
      r_base_row <= '0;
      r_base_col <= '0;
    end else if (w_capture) begin
      r_base_n   <= tile_base_n;
      r_base_row <= tile_base_row;
      r_base_col <= tile_base_col;
    end
  end

  tile_idx_counter3 #(
    .D0(Tc), .D1(Tr), .D2(Tn),
    .W0(WC), .W1(WR), .W2(WN)
  ) u_idx (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_capture),
    .en   (w_pop),
    .cnt0 (w_cnt_c),
    .cnt1 (w_cnt_r),
    .cnt2 (w_cnt_n),
    .last (w_last)
  );

  // One extra bit keeps a large base from wrapping back into the legal range.
  assign w_n_sum = {1'b0, r_base_n}   + (AW+1)'(w_cnt_n);
  assign w_r_sum = {1'b0, r_base_row} + (AW+1)'(w_cnt_r);
  assign w_c_sum = {1'b0, r_base_col} + (AW+1)'(w_cnt_c);
  assign w_legal = (w_n_sum < LP_LIM_N) && (w_r_sum < LP_LIM_R) && (w_c_sum < LP_LIM_C);
  assign w_addr  = w_n_sum[AW-1:0] * LP_RC + w_r_sum[AW-1:0] * LP_C + w_c_sum[AW-1:0];

  // Stage 1: address and legality ride alongside the word that arrives next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_legal <= 1'b0;
      r_s1_addr  <= '0;
    end else begin
      r_s1_valid <= w_pop;
      if (w_pop) begin
        r_s1_legal <= w_legal;
        r_s1_addr  <= w_addr;
      end
    end
  end

  // Stage 2: registered RAM write port; illegal words are consumed without a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= r_s1_valid && r_s1_legal;
      if (r_s1_valid) begin
        r_addr <= r_s1_addr;
        r_data <= data_from_fifo;
      end
    end
  end

  assign ram_we      = r_we;
  assign ram_addr    = r_addr;
  assign data_to_ram = r_data;

endmodule

// File: tb/tb_fifo_to_out_fm_ram.sv
// tb/tb_fifo_to_out_fm_ram.sv - self-checking bench for the FIFO-to-output-RAM tile writer
module tb_fifo_to_out_fm_ram;

  localparam int P_N  = 4;
  localparam int P_R  = 6;
  localparam int P_C  = 5;
  localparam int P_TN = 2;
  localparam int P_TR = 4;
  localparam int P_TC = 4;
  localparam int TOTAL = P_TN * P_TR * P_TC;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        done;
  logic        fifo_pop;
  logic        fifo_empty;
  logic [31:0] data_from_fifo;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] data_to_ram;
  logic [31:0] tile_base_n;
  logic [31:0] tile_base_row;
  logic [31:0] tile_base_col;

  int n_vec;
  int n_err;

  int          act_addr[$];
  int unsigned act_data[$];
  int          act_pops;
  bit          act_done;

  fifo_to_out_fm_ram #(
    .AW(32), .DW(32), .N(P_N), .R(P_R), .C(P_C),
    .Tn(P_TN), .Tr(P_TR), .Tc(P_TC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .done          (done),
    .fifo_pop      (fifo_pop),
    .fifo_empty    (fifo_empty),
    .data_from_fifo(data_from_fifo),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .data_to_ram   (data_to_ram),
    .tile_base_n   (tile_base_n),
    .tile_base_row (tile_base_row),
    .tile_base_col (tile_base_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic pick_empty(input int emode, input int cyc);
    case (emode)
      1:       return (cyc % 2) == 1;
      2:       return $urandom_range(0, 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Runs one tile and checks every pop, write and the done pulse against a reference
  // built from the tile geometry: writes are the in-range tile elements in pop order,
  // each landing two cycles after its pop, done three cycles after the final pop.
  task automatic run_tile(input int bn, input int br, input int bc, input int emode,
                          input bit seq, input bit repulse, input string tag);
    int unsigned words[$];
    int          exp_a[$];
    int unsigned exp_d[$];
    int          exp_k[$];
    int          pop_cyc[$];
    int          pops;
    int          wr;
    int          k;
    bit          prev_pop;
    bit          got_done;
    logic        exp_pop;
    for (int i = 0; i < TOTAL; i++) words.push_back(seq ? i : $urandom);
    k = 0;
    for (int n = 0; n < P_TN; n++)
      for (int r = 0; r < P_TR; r++)
        for (int c = 0; c < P_TC; c++) begin
          if (bn + n < P_N && br + r < P_R && bc + c < P_C) begin
            exp_a.push_back((bn + n) * P_R * P_C + (br + r) * P_C + (bc + c));
            exp_d.push_back(words[k]);
            exp_k.push_back(k);
          end
          k++;
        end
    act_addr.delete();
    act_data.delete();
    pops = 0; wr = 0; prev_pop = 0; got_done = 0;

    @(posedge clk); #1;
    tile_base_n = bn; tile_base_row = br; tile_base_col = bc;
    start = 1'b1;
    fifo_empty = pick_empty(emode, 0);
    @(negedge clk);
    n_vec++;
    if (fifo_pop !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_outputs: pop=%b done=%b we=%b want 0 0 0", tag, fifo_pop, done, ram_we);
    end

    for (int cyc = 1; cyc <= 400 && !got_done; cyc++) begin
      @(posedge clk); #1;
      start = repulse && (cyc == 6);
      tile_base_n = $urandom; tile_base_row = $urandom; tile_base_col = $urandom;
      if (prev_pop) data_from_fifo = (pops <= TOTAL) ? words[pops-1] : 32'h0;
      fifo_empty = pick_empty(emode, cyc);
      @(negedge clk);
      exp_pop = (pops < TOTAL) && !fifo_empty;
      n_vec++;
      if (fifo_pop !== exp_pop) begin
        n_err++;
        $display("FAIL %s pop cyc %0d: got %b want %b", tag, cyc, fifo_pop, exp_pop);
      end
      prev_pop = (fifo_pop === 1'b1);
      if (prev_pop) begin
        pop_cyc.push_back(cyc);
        pops++;
      end
      if (ram_we === 1'b1) begin
        act_addr.push_back(ram_addr);
        act_data.push_back(data_to_ram);
        n_vec++;
        if (wr >= exp_a.size()) begin
          n_err++;
          $display("FAIL %s extra_write cyc %0d: addr %0d, want no write", tag, cyc, ram_addr);
        end else if (ram_addr !== exp_a[wr] || data_to_ram !== exp_d[wr] ||
                     exp_k[wr] >= pop_cyc.size() || cyc != pop_cyc[exp_k[wr]] + 2) begin
          n_err++;
          $display("FAIL %s write %0d cyc %0d: addr %0d data %0h, want addr %0d data %0h two cycles after pop %0d",
                   tag, wr, cyc, ram_addr, data_to_ram, exp_a[wr], exp_d[wr], exp_k[wr]);
        end
        wr++;
      end
      if (done === 1'b1) begin
        got_done = 1;
        n_vec++;
        if (pops != TOTAL || wr != exp_a.size() || pop_cyc.size() == 0 ||
            cyc != pop_cyc[pop_cyc.size()-1] + 3) begin
          n_err++;
          $display("FAIL %s done cyc %0d: pops %0d writes %0d, want pops %0d writes %0d done 3 after last pop",
                   tag, cyc, pops, wr, TOTAL, exp_a.size());
        end
      end
    end
    start = 1'b0;
    n_vec++;
    if (!got_done) begin
      n_err++;
      $display("FAIL %s done_timeout: got no done, want one within 400 cycles", tag);
    end
    act_pops = pops;
    act_done = got_done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; fifo_empty = 1'b0; data_from_fifo = $urandom;
    tile_base_n = 0; tile_base_row = 0; tile_base_col = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (fifo_pop !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 32'h0 || data_to_ram !== 32'h0) begin
        n_err++;
        $display("FAIL reset_outputs: pop=%b done=%b we=%b addr=%h data=%h want all 0",
                 fifo_pop, done, ram_we, ram_addr, data_to_ram);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (fifo_pop !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after_reset: pop=%b done=%b we=%b want 0 0 0", fifo_pop, done, ram_we);
      end
    end
  endtask

  task automatic test_interior();
    run_tile(0, 0, 0, 0, 1'b1, 1'b0, "interior");
    n_vec++;
    if (act_pops != 32 || act_addr.size() != 32) begin
      n_err++;
      $display("FAIL interior_counts: pops %0d writes %0d, want 32 32", act_pops, act_addr.size());
    end else if (act_addr[0] != 0 || act_data[0] != 0 || act_addr[3] != 3 || act_addr[4] != 5 ||
                 act_addr[31] != 48 || act_data[31] != 31) begin
      n_err++;
      $display("FAIL interior_points: a0 %0d d0 %0d a3 %0d a4 %0d a31 %0d d31 %0d, want 0 0 3 5 48 31",
               act_addr[0], act_data[0], act_addr[3], act_addr[4], act_addr[31], act_data[31]);
    end
  endtask

  task automatic test_edge();
    run_tile(2, 4, 3, 0, 1'b1, 1'b0, "edge");
    n_vec++;
    if (act_pops != 32 || act_addr.size() != 8) begin
      n_err++;
      $display("FAIL edge_counts: pops %0d writes %0d, want 32 8", act_pops, act_addr.size());
    end else if (act_addr[0] != 83 || act_data[0] != 0 || act_addr[1] != 84 || act_data[1] != 1 ||
                 act_addr[2] != 88 || act_data[2] != 4) begin
      n_err++;
      $display("FAIL edge_points: %0d/%0d %0d/%0d %0d/%0d, want 83/0 84/1 88/4",
               act_addr[0], act_data[0], act_addr[1], act_data[1], act_addr[2], act_data[2]);
    end
  endtask

  task automatic test_out_of_range();
    run_tile(4, 0, 0, 0, 1'b0, 1'b0, "oor");
    n_vec++;
    if (act_pops != 32 || act_addr.size() != 0 || !act_done) begin
      n_err++;
      $display("FAIL oor_counts: pops %0d writes %0d done %0b, want 32 0 1", act_pops, act_addr.size(), act_done);
    end
  endtask

  task automatic test_backpressure();
    run_tile(0, 0, 0, 1, 1'b1, 1'b0, "toggle");
    n_vec++;
    if (act_addr.size() != 32) begin
      n_err++;
      $display("FAIL toggle_writes: got %0d writes, want 32", act_addr.size());
    end
    run_tile(1, 2, 1, 2, 1'b0, 1'b0, "rand_empty");
  endtask

  task automatic test_disturb();
    int pops;
    run_tile(0, 1, 2, 0, 1'b0, 1'b1, "restart_pulse");
    pops = 0;
    @(posedge clk); #1;
    tile_base_n = 0; tile_base_row = 0; tile_base_col = 0;
    start = 1'b1; fifo_empty = 1'b0; data_from_fifo = 32'hdead_beef;
    for (int i = 0; i < 50 && pops < 10; i++) begin
      @(negedge clk);
      if (fifo_pop === 1'b1) pops++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (fifo_pop !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 32'h0 || data_to_ram !== 32'h0) begin
      n_err++;
      $display("FAIL midrun_reset: pop=%b done=%b we=%b addr=%h data=%h want all 0",
               fifo_pop, done, ram_we, ram_addr, data_to_ram);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (fifo_pop !== 1'b0 || ram_we !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_idle: pop=%b we=%b done=%b want 0 0 0", fifo_pop, ram_we, done);
      end
    end
    run_tile(0, 0, 0, 0, 1'b1, 1'b0, "after_reset");
    n_vec++;
    if (act_addr.size() != 32 || act_addr[0] != 0 || act_data[0] != 0) begin
      n_err++;
      $display("FAIL restart_index: writes %0d first addr %0d, want 32 writes from addr 0 data 0",
               act_addr.size(), (act_addr.size() > 0) ? act_addr[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_tile($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 5),
               $urandom_range(0, 2), 1'b0, 1'b0, "b2b_rand");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || fifo_pop !== 1'b0 || ram_we !== 1'b0) begin
        n_err++;
        $display("FAIL trailing_idle: done=%b pop=%b we=%b want 0 0 0", done, fifo_pop, ram_we);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_interior();
    test_edge();
    test_out_of_range();
    test_backpressure();
    test_disturb();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
